// File: rtl/lsu_data_memory.sv
// Byte-addressed, single-port data memory for the RISC-V datapath.
// Handles LB/LH/LW/LBU/LHU/SB/SH/SW with little-endian lane masking,
// sign/zero extension and fault reporting. Requests use a req/ready
// handshake; each accepted request produces exactly one rsp_valid pulse
// after WAIT_CYCLES stall cycles.
module lsu_data_memory #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wr_data,
    output logic              o_ready,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rd_data,
    output logic [1:0]        o_fault
);

    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] WAIT_LAST = 3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] F_OK    = 2'b00;
    localparam logic [1:0] F_MIS   = 2'b01;
    localparam logic [1:0] F_RANGE = 2'b10;
    localparam logic [1:0] F_ILL   = 2'b11;

    logic [31:0]       mem_q [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       rd_hold_q, rd_hold_d;
    logic [1:0]        fault_hold_q, fault_hold_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic [1:0]        fault_q, fault_d;

    logic              accept;
    logic [ADDR_W-1:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              legal, misalign, out_of_range;
    logic [1:0]        fault_req;
    logic [31:0]       rd_word, rd_shift, rd_ext;
    logic [15:0]       rd_half;
    logic [3:0]        wr_be;
    logic [31:0]       wr_lane;
    logic              mem_we;

    assign o_ready     = (state_q == ST_IDLE) && !rst;
    assign accept      = i_req && o_ready;
    assign word_idx    = ADDR_W'(i_addr[ADDR_W-1:2]);
    assign mem_idx     = word_idx[IDX_W-1:0];
    assign mem_we      = accept && i_we && (fault_req == F_OK);

    // Decode the incoming request: fault class, extended load data, store lanes.
    always_comb begin
        legal = 1'b0;
        case (i_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !i_we;  // unsigned forms exist only for loads
            default:                legal = 1'b0;
        endcase
        misalign     = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                       ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
        // The full upper address is compared so high bits never alias into the array.
        out_of_range = word_idx >= ADDR_W'(DEPTH);

        if (!legal)            fault_req = F_ILL;
        else if (misalign)     fault_req = F_MIS;
        else if (out_of_range) fault_req = F_RANGE;
        else                   fault_req = F_OK;

        rd_word  = mem_q[mem_idx];
        rd_shift = rd_word >> {i_addr[1:0], 3'b000};
        rd_half  = i_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (i_funct3)
            3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b010:  rd_ext = rd_word;
            3'b100:  rd_ext = {24'd0, rd_shift[7:0]};
            3'b101:  rd_ext = {16'd0, rd_half};
            default: rd_ext = 32'd0;
        endcase
        if (i_we || (fault_req != F_OK)) rd_ext = 32'd0;

        case (i_funct3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << i_addr[1:0];
                wr_lane = {4{i_wr_data[7:0]}};
            end
            2'b01: begin
                wr_be   = i_addr[1] ? 4'b1100 : 4'b0011;
                wr_lane = {2{i_wr_data[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_lane = i_wr_data;
            end
        endcase
    end

    // Sequencing: capture the response at accept, stall, then strobe it out.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_hold_d    = rd_hold_q;
        fault_hold_d = fault_hold_q;
        rd_data_d    = rd_data_q;
        fault_d      = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rd_hold_d    = rd_ext;
                    fault_hold_d = fault_req;
                    cnt_d        = 3'd0;
                    state_d      = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) state_d = ST_RESP;
                else                    cnt_d   = cnt_q + 3'd1;
            end
            ST_RESP: begin
                // Keep the last response visible after the strobe drops.
                rd_data_d = rd_hold_q;
                fault_d   = fault_hold_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and response registers; reset drops any outstanding response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            rd_hold_q    <= 32'd0;
            fault_hold_q <= F_OK;
            rd_data_q    <= 32'd0;
            fault_q      <= F_OK;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_hold_q    <= rd_hold_d;
            fault_hold_q <= fault_hold_d;
            rd_data_q    <= rd_data_d;
            fault_q      <= fault_d;
        end
    end

    // Store commit on the accept edge with per-byte enables; array is not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem_q[mem_idx][8*b +: 8] <= wr_lane[8*b +: 8];
            end
        end
    end

    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_rd_data   = (state_q == ST_RESP) ? rd_hold_q : rd_data_q;
    assign o_fault     = (state_q == ST_RESP) ? fault_hold_q : fault_q;

endmodule

// File: tb/tb_lsu_data_memory.sv
// Bench for lsu_data_memory: unit 0 has no wait states, unit 1 has three.
// Directed table, hand-written stall/reset sequences and random traffic
// checked against a byte-array reference model.
module tb_lsu_data_memory;

    logic             clk = 1'b0;
    logic [1:0]       rst;
    logic [1:0]       req, we;
    logic [1:0][2:0]  f3;
    logic [1:0][31:0] addr, wdata;
    logic [1:0]       rdy, rspv;
    logic [1:0][31:0] rdd;
    logic [1:0][1:0]  flt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    lsu_data_memory #(.DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst[0]), .i_req(req[0]), .i_we(we[0]), .i_funct3(f3[0]),
        .i_addr(addr[0]), .i_wr_data(wdata[0]), .o_ready(rdy[0]),
        .o_rsp_valid(rspv[0]), .o_rd_data(rdd[0]), .o_fault(flt[0]));

    lsu_data_memory #(.DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst[1]), .i_req(req[1]), .i_we(we[1]), .i_funct3(f3[1]),
        .i_addr(addr[1]), .i_wr_data(wdata[1]), .o_ready(rdy[1]),
        .o_rsp_valid(rspv[1]), .o_rd_data(rdd[1]), .o_fault(flt[1]));

    // Reference memory: one byte array per unit, plain byte addressing.
    logic [7:0] ref_mem [2][1024];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    // Architectural model of one access, from the ISA rules.
    task automatic ref_access(input int u, input bit w, input bit [2:0] fn, input bit [31:0] a,
                              input bit [31:0] wd, output bit [31:0] rd, output bit [1:0] fl);
        int size;
        bit ok;
        longint val;
        ok   = w ? (fn <= 3'd2) : (fn <= 3'd2 || fn == 3'd4 || fn == 3'd5);
        size = 1 << fn[1:0];
        rd   = 0;
        if (!ok)                      fl = 2'b11;
        else if (a % size != 0)       fl = 2'b01;
        else if (a / 4 >= 256)        fl = 2'b10;
        else begin
            fl = 2'b00;
            if (w) begin
                for (int i = 0; i < size; i++) ref_mem[u][a + i] = 8'(wd >> (8 * i));
            end else begin
                val = 0;
                for (int i = 0; i < size; i++) val += longint'(ref_mem[u][a + i]) << (8 * i);
                if (!fn[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
                    val -= longint'(1) << (8 * size);
                rd = 32'(val);
            end
        end
    endtask

    // One complete transaction: wait for ready, present for one edge, collect response.
    task automatic txn(input int u, input bit w, input bit [2:0] fn, input bit [31:0] a,
                       input bit [31:0] wd, output bit [31:0] rd, output bit [1:0] fl,
                       output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[u]) chk("ready_timeout", 0, 1);
        req[u] = 1'b1; we[u] = w; f3[u] = fn; addr[u] = a; wdata[u] = wd;
        @(negedge clk);
        req[u] = 1'b0;
        addr[u] = $urandom; wdata[u] = $urandom;   // captured fields must not matter now
        lat = 1;
        while (!rspv[u] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rdd[u];
        fl = flt[u];
        @(negedge clk);
        chk("rsp_pulse_len", rspv[u], 0);
    endtask

    typedef struct {
        int        u;
        bit        w;
        bit [2:0]  fn;
        bit [31:0] a;
        bit [31:0] wd;
        bit [31:0] rd;
        bit [1:0]  fl;
    } vec_t;

    vec_t tbl[19];

    initial begin
        bit [31:0] rd, erd, a;
        bit [1:0]  fl, efl;
        bit [2:0]  fn;
        bit        w;
        int        lat, cnt;

        tbl[0]  = '{0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        2'b00};
        tbl[1]  = '{0, 0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 2'b00};
        tbl[2]  = '{0, 0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 2'b00};
        tbl[3]  = '{0, 0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 2'b00};
        tbl[4]  = '{0, 0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 2'b00};
        tbl[5]  = '{0, 0, 3'b101, 32'h10,  32'h0,        32'h0000BEEF, 2'b00};
        tbl[6]  = '{0, 1, 3'b000, 32'h11,  32'h12345655, 32'h0,        2'b00};
        tbl[7]  = '{0, 1, 3'b001, 32'h12,  32'h0000A5A5, 32'h0,        2'b00};
        tbl[8]  = '{0, 0, 3'b010, 32'h10,  32'h0,        32'hA5A555EF, 2'b00};
        tbl[9]  = '{0, 0, 3'b010, 32'h12,  32'h0,        32'h0,        2'b01};
        tbl[10] = '{0, 1, 3'b001, 32'h13,  32'hFFFFFFFF, 32'h0,        2'b01};
        tbl[11] = '{0, 0, 3'b010, 32'h10,  32'h0,        32'hA5A555EF, 2'b00};
        tbl[12] = '{0, 0, 3'b010, 32'h400, 32'h0,        32'h0,        2'b10};
        tbl[13] = '{0, 0, 3'b011, 32'h13,  32'h0,        32'h0,        2'b11};
        tbl[14] = '{0, 1, 3'b100, 32'h10,  32'h0,        32'h0,        2'b11};
        tbl[15] = '{1, 1, 3'b010, 32'h3FC, 32'h11223344, 32'h0,        2'b00};
        tbl[16] = '{1, 0, 3'b001, 32'h3FE, 32'h0,        32'h00001122, 2'b00};
        tbl[17] = '{1, 1, 3'b010, 32'hFFFFFFFC, 32'h0BADBAD0, 32'h0,   2'b10};
        tbl[18] = '{1, 0, 3'b010, 32'h3FC, 32'h0,        32'h11223344, 2'b00};

        rst = 2'b11; req = '0; we = '0; f3 = '0; addr = '0; wdata = '0;

        // Reset values, during and right after reset.
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst%0d_ready", u), rdy[u], 0);
            chk($sformatf("rst%0d_rsp", u), rspv[u], 0);
            chk($sformatf("rst%0d_rd", u), rdd[u], 0);
            chk($sformatf("rst%0d_fault", u), flt[u], 0);
        end
        rst = 2'b00;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("post_rst%0d_ready", u), rdy[u], 1);
            chk($sformatf("post_rst%0d_rsp", u), rspv[u], 0);
            chk($sformatf("post_rst%0d_rd", u), rdd[u], 0);
            chk($sformatf("post_rst%0d_fault", u), flt[u], 0);
        end

        // Directed vectors.
        for (int i = 0; i < 19; i++) begin
            txn(tbl[i].u, tbl[i].w, tbl[i].fn, tbl[i].a, tbl[i].wd, rd, fl, lat);
            ref_access(tbl[i].u, tbl[i].w, tbl[i].fn, tbl[i].a, tbl[i].wd, erd, efl);
            chk($sformatf("tbl%0d_rd", i), rd, tbl[i].rd);
            chk($sformatf("tbl%0d_fault", i), 32'(fl), 32'(tbl[i].fl));
            chk($sformatf("tbl%0d_latency", i), lat, (tbl[i].u == 0) ? 1 : 4);
        end

        // Stall with i_req held high: one accept, one response, ready timing.
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; f3[1] = 3'b010; addr[1] = 32'h40; wdata[1] = 32'h55AA55AA;
        ref_access(1, 1, 3'b010, 32'h40, 32'h55AA55AA, erd, efl);
        cnt = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("stall_ready_t%0d", k), rdy[1], 0);
            chk($sformatf("stall_rsp_t%0d", k), rspv[1], (k == 4));
            cnt += rspv[1];
        end
        req[1] = 1'b0;
        @(negedge clk);
        chk("stall_ready_t5", rdy[1], 1);
        repeat (6) begin
            cnt += rspv[1];
            @(negedge clk);
        end
        chk("stall_rsp_count", cnt, 1);

        // Reset in the middle of a stalled store.
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; f3[1] = 3'b010; addr[1] = 32'h20; wdata[1] = 32'hCAFEF00D;
        ref_access(1, 1, 3'b010, 32'h20, 32'hCAFEF00D, erd, efl);
        @(negedge clk);
        req[1] = 1'b0;
        rst[1] = 1'b1;
        cnt = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("midrst_ready", rdy[1], 0);
            chk("midrst_rd", rdd[1], 0);
            chk("midrst_fault", flt[1], 0);
            cnt += rspv[1];
        end
        rst[1] = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", rdy[1], 1);
        repeat (6) begin
            cnt += rspv[1];
            @(negedge clk);
        end
        chk("midrst_rsp_count", cnt, 0);
        txn(1, 0, 3'b010, 32'h20, 32'h0, rd, fl, lat);
        chk("midrst_load_rd", rd, 32'hCAFEF00D);
        chk("midrst_load_fault", 32'(fl), 0);

        // Random traffic against the reference model; words 0..63 initialised first.
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 64; i++) begin
                a = 32'(i * 4);
                erd = $urandom;
                txn(u, 1, 3'b010, a, erd, rd, fl, lat);
                ref_access(u, 1, 3'b010, a, erd, erd, efl);
                chk("init_fault", 32'(fl), 32'(efl));
            end
            for (int i = 0; i < 200; i++) begin
                w  = 1'($urandom_range(0, 1));
                fn = ($urandom_range(0, 9) < 8)
                   ? ((($urandom_range(0, 1) == 1) && !w) ? 3'(4 + $urandom_range(0, 1))
                                                          : 3'($urandom_range(0, 2)))
                   : 3'($urandom_range(0, 7));
                if ($urandom_range(0, 9) == 0)
                    a = ($urandom_range(0, 1) == 1) ? (32'h400 + 32'($urandom_range(0, 255)))
                                                    : ($urandom | 32'h8000_0000);
                else
                    a = 32'($urandom_range(0, 255));
                erd = $urandom;
                txn(u, w, fn, a, erd, rd, fl, lat);
                ref_access(u, w, fn, a, erd, erd, efl);
                chk($sformatf("rnd%0d_%0d_rd", u, i), rd, erd);
                chk($sformatf("rnd%0d_%0d_fault", u, i), 32'(fl), 32'(efl));
                chk($sformatf("rnd%0d_%0d_latency", u, i), lat, (u == 0) ? 1 : 4);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
